// File: rtl/firewall_pkg.sv
// Shared constants and types for the RMII firewall controller.
// Imported by firewall_ctrl and its bench.
package firewall_pkg;

  localparam int MAC_W      = 48;
  localparam int MAC_BYTES  = MAC_W / 8;
  localparam int MAC_DIBITS = 24;

  localparam logic [MAC_W-1:0] DEFAULT_MAC   = 48'h69695A065491;
  localparam logic [MAC_W-1:0] BROADCAST_MAC = 48'hFFFFFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    TAIL
  } fw_ctrl_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; the count never wraps.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  // next count: clear, saturating increment, or hold
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  // count register, active-low synchronous reset
  always_ff @(posedge clk) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/firewall_ctrl.sv
// Config and frame sequencing for the RMII rx firewall.
// New MAC/promisc settings only land between frames.
module firewall_ctrl
  import firewall_pkg::*;
#(
  parameter logic [47:0] DEFAULT_MAC = firewall_pkg::DEFAULT_MAC,
  parameter int          CNT_W       = 16,
  parameter int          TAIL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [7:0]       cfg_data,
  output logic             cfg_ready,
  input  logic             cfg_promisc,
  input  logic             stats_clr,
  input  logic             rx_axiiv,
  input  logic             fw_axiov,
  output logic [47:0]      mac_out,
  output logic             promisc_out,
  output logic             busy,
  output logic             cfg_pending,
  output logic [CNT_W-1:0] frames_seen,
  output logic [CNT_W-1:0] frames_passed,
  output logic [CNT_W-1:0] frames_dropped,
  output logic [CNT_W-1:0] frames_runt
);

  localparam int         TW      = $clog2(TAIL_CYCLES + 1);
  localparam logic [5:0] LEN_MAX = 6'd63;

  fw_ctrl_state_t   state_q, state_d;
  logic [5:0]       len_q, len_d;
  logic             hit_q, hit_d;
  logic [TW-1:0]    tail_q, tail_d;
  logic [2:0]       byte_idx_q, byte_idx_d;
  logic [MAC_W-1:0] shadow_q, shadow_d;
  logic [MAC_W-1:0] mac_q, mac_d;
  logic             pend_q, pend_d;
  logic             promisc_q, promisc_d;

  logic close, close_hit, runt;
  logic accept, commit_ok;
  logic inc_seen, inc_pass, inc_drop, inc_runt;

  // config shadow load and between-frame commit
  always_comb begin
    shadow_d   = shadow_q;
    byte_idx_d = byte_idx_q;
    pend_d     = pend_q;
    mac_d      = mac_q;
    promisc_d  = promisc_q;
    accept     = cfg_valid && !pend_q;
    commit_ok  = (state_q == IDLE) && !rx_axiiv;
    if (accept) begin
      for (int i = 0; i < MAC_BYTES; i++) begin
        if (byte_idx_q == 3'(i)) begin
          shadow_d[MAC_W-1-8*i -: 8] = cfg_data;
        end
      end
      if (byte_idx_q == 3'(MAC_BYTES - 1)) begin
        pend_d     = 1'b1;
        byte_idx_d = '0;
      end else begin
        byte_idx_d = byte_idx_q + 3'd1;
      end
    end
    if (commit_ok) begin
      promisc_d = cfg_promisc;
      if (pend_q) begin
        mac_d  = shadow_q;
        pend_d = 1'b0;
      end
    end
  end

  // frame tracking; a TAIL window lets late fw output count
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    hit_d     = hit_q;
    tail_d    = tail_q;
    close     = 1'b0;
    close_hit = hit_q | fw_axiov;
    unique case (state_q)
      IDLE: begin
        if (rx_axiiv) begin
          state_d = FRAME;
          len_d   = 6'd1;
          hit_d   = fw_axiov;
        end
      end
      FRAME: begin
        hit_d = hit_q | fw_axiov;
        if (rx_axiiv) begin
          if (len_q != LEN_MAX) len_d = len_q + 6'd1;
        end else begin
          state_d = TAIL;
          tail_d  = TW'(1);
        end
      end
      TAIL: begin
        hit_d  = hit_q | fw_axiov;
        tail_d = tail_q + TW'(1);
        if (rx_axiiv) begin
          close   = 1'b1;
          state_d = FRAME;
          len_d   = 6'd1;
          hit_d   = fw_axiov;
        end else if (tail_q == TW'(TAIL_CYCLES)) begin
          close   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign runt     = len_q < 6'(MAC_DIBITS);
  assign inc_seen = close;
  assign inc_runt = close && runt;
  assign inc_pass = close && !runt && close_hit;
  assign inc_drop = close && (runt || !close_hit);

  // state and config registers, active-low synchronous reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      hit_q      <= 1'b0;
      tail_q     <= '0;
      byte_idx_q <= '0;
      shadow_q   <= '0;
      mac_q      <= DEFAULT_MAC;
      pend_q     <= 1'b0;
      promisc_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      hit_q      <= hit_d;
      tail_q     <= tail_d;
      byte_idx_q <= byte_idx_d;
      shadow_q   <= shadow_d;
      mac_q      <= mac_d;
      pend_q     <= pend_d;
      promisc_q  <= promisc_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_seen (
    .clk(clk), .rst(rst), .inc(inc_seen),
    .clr(stats_clr), .q(frames_seen)
  );
  sat_counter #(.W(CNT_W)) u_pass (
    .clk(clk), .rst(rst), .inc(inc_pass),
    .clr(stats_clr), .q(frames_passed)
  );
  sat_counter #(.W(CNT_W)) u_drop (
    .clk(clk), .rst(rst), .inc(inc_drop),
    .clr(stats_clr), .q(frames_dropped)
  );
  sat_counter #(.W(CNT_W)) u_runt (
    .clk(clk), .rst(rst), .inc(inc_runt),
    .clr(stats_clr), .q(frames_runt)
  );

  assign mac_out     = mac_q;
  assign promisc_out = promisc_q;
  assign busy        = (state_q != IDLE);
  assign cfg_pending = pend_q;
  assign cfg_ready   = !pend_q;

endmodule

// File: tb/tb_firewall_ctrl.sv
// Scoreboard bench for firewall_ctrl.
// A 2-bit-counter copy shares all stimulus.
module tb_firewall_ctrl;
  import firewall_pkg::*;

  typedef struct {
    logic [47:0] mac;
    int          edge_n;
  } mac_exp_t;

  typedef struct {
    int seen;
    int passed;
    int dropped;
    int runt;
  } st_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cfg_valid = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic cfg_promisc = 1'b0;
  logic stats_clr = 1'b0;
  logic rx = 1'b0;
  logic fw = 1'b0;

  logic        cfg_ready, promisc_out, busy, cfg_pending;
  logic [47:0] mac_out;
  logic [15:0] seen, passed, dropped, runt;

  logic        s_ready, s_promisc, s_busy, s_pending;
  logic [47:0] s_mac;
  logic [1:0]  s_seen, s_passed, s_dropped, s_runt;

  firewall_ctrl u_dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .cfg_promisc(cfg_promisc),
    .stats_clr(stats_clr), .rx_axiiv(rx), .fw_axiov(fw),
    .mac_out(mac_out), .promisc_out(promisc_out),
    .busy(busy), .cfg_pending(cfg_pending),
    .frames_seen(seen), .frames_passed(passed),
    .frames_dropped(dropped), .frames_runt(runt)
  );

  firewall_ctrl #(.CNT_W(2)) u_small (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(s_ready), .cfg_promisc(cfg_promisc),
    .stats_clr(stats_clr), .rx_axiiv(rx), .fw_axiov(fw),
    .mac_out(s_mac), .promisc_out(s_promisc),
    .busy(s_busy), .cfg_pending(s_pending),
    .frames_seen(s_seen), .frames_passed(s_passed),
    .frames_dropped(s_dropped), .frames_runt(s_runt)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  mac_exp_t mac_q[$];
  st_exp_t  st_q[$];
  int m_seen, m_pass, m_drop, m_runt;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic model_clr();
    m_seen = 0; m_pass = 0; m_drop = 0; m_runt = 0;
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic expect_close(input int len, input bit hit);
    m_seen = sat16(m_seen + 1);
    if (len < 24) begin
      m_runt = sat16(m_runt + 1);
      m_drop = sat16(m_drop + 1);
    end else if (hit) begin
      m_pass = sat16(m_pass + 1);
    end else begin
      m_drop = sat16(m_drop + 1);
    end
    st_q.push_back('{m_seen, m_pass, m_drop, m_runt});
  endtask

  task automatic load_mac(input logic [47:0] m);
    for (int i = 0; i < 6; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = m[47-8*i -: 8];
      tick();
    end
    cfg_valid = 1'b0;
  endtask

  // n dibits, then gap idle cycles with fw pulse at gap offset
  task automatic frame(input int n, input bit fw_hold,
                       input int pulse, input int gap);
    for (int k = 0; k < n; k++) begin
      rx = 1'b1;
      fw = fw_hold;
      tick();
    end
    rx = 1'b0;
    for (int t = 0; t < gap; t++) begin
      fw = (t == pulse);
      tick();
    end
    fw = 1'b0;
  endtask

  task automatic chk_stats(input string nm, input int s, input int p,
                           input int d, input int r);
    chk({nm, "_seen"}, 64'(seen), 64'(s));
    chk({nm, "_passed"}, 64'(passed), 64'(p));
    chk({nm, "_dropped"}, 64'(dropped), 64'(d));
    chk({nm, "_runt"}, 64'(runt), 64'(r));
  endtask

  logic [47:0] prev_mac;
  logic [15:0] prev_seen;

  // monitor: mac_out changes and frame closes pop the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (mac_out !== prev_mac) begin
        if (mac_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL mac_unexpected: got %0h want no change",
                   mac_out);
        end else begin
          mac_exp_t e;
          e = mac_q.pop_front();
          chk("mac_value", 64'(mac_out), 64'(e.mac));
          chk("mac_edge", 64'(cyc), 64'(e.edge_n));
        end
      end
      if (seen > prev_seen) begin
        if (st_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL stats_unexpected: got seen %0d want no close",
                   seen);
        end else begin
          st_exp_t e;
          e = st_q.pop_front();
          chk("sb_seen", 64'(seen), 64'(e.seen));
          chk("sb_passed", 64'(passed), 64'(e.passed));
          chk("sb_dropped", 64'(dropped), 64'(e.dropped));
          chk("sb_runt", 64'(runt), 64'(e.runt));
        end
      end
    end
    prev_mac  = mac_out;
    prev_seen = seen;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int base;
    logic [47:0] m1, m2;
    m1 = 48'h021122334455;
    m2 = 48'hA1B2C3D4E5F6;
    model_clr();

    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (5) tick();
    chk("rst_mac", 64'(mac_out), 64'(DEFAULT_MAC));
    chk("rst_promisc", 64'(promisc_out), 64'd0);
    chk("rst_ready", 64'(cfg_ready), 64'd1);
    chk("rst_pending", 64'(cfg_pending), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk_stats("rst", 0, 0, 0, 0);
    mon_en = 1'b1;

    base = cyc + 1;
    mac_q.push_back('{m1, base + 6});
    load_mac(m1);
    chk("load_pending_hi", 64'(cfg_pending), 64'd1);
    chk("load_ready_lo", 64'(cfg_ready), 64'd0);
    tick();
    chk("load_pending_lo", 64'(cfg_pending), 64'd0);
    chk("load_ready_hi", 64'(cfg_ready), 64'd1);
    chk("load_mac", 64'(mac_out), 64'(m1));

    expect_close(60, 1'b0);
    base = cyc + 1;
    mac_q.push_back('{m2, base + 65});
    for (int k = 0; k < 60; k++) begin
      rx = 1'b1;
      cfg_valid = (k >= 10 && k < 16);
      cfg_data  = m2[47-8*((k >= 10 && k < 16) ? k - 10 : 0) -: 8];
      tick();
    end
    rx = 1'b0;
    cfg_valid = 1'b0;
    chk("mid_pending", 64'(cfg_pending), 64'd1);
    chk("mid_mac_hold", 64'(mac_out), 64'(m1));
    repeat (4) tick();
    chk("tail_busy", 64'(busy), 64'd1);
    tick();
    chk("close_idle", 64'(busy), 64'd0);
    chk("close_mac_hold", 64'(mac_out), 64'(m1));
    tick();
    chk("commit_mac", 64'(mac_out), 64'(m2));
    chk_stats("f60", 1, 0, 1, 0);

    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    model_clr();
    chk_stats("clr", 0, 0, 0, 0);

    expect_close(24, 1'b0);
    frame(24, 1'b0, -1, 6);
    expect_close(60, 1'b1);
    frame(60, 1'b0, 2, 6);
    chk_stats("pair", 2, 1, 1, 0);

    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    model_clr();
    expect_close(10, 1'b1);
    frame(10, 1'b1, -1, 6);
    chk_stats("runt10", 1, 0, 1, 1);
    expect_close(23, 1'b1);
    frame(23, 1'b1, -1, 6);
    chk_stats("runt23", 2, 0, 2, 2);

    expect_close(30, 1'b0);
    expect_close(30, 1'b1);
    frame(30, 1'b0, -1, 2);
    frame(30, 1'b0, 3, 6);
    chk_stats("b2b", 4, 1, 3, 2);

    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    model_clr();
    for (int f = 0; f < 5; f++) begin
      expect_close(30, 1'b0);
      frame(30, 1'b0, -1, 6);
    end
    chk("sat_dropped", 64'(s_dropped), 64'd3);
    chk("sat_seen", 64'(s_seen), 64'd3);
    chk("sat_passed", 64'(s_passed), 64'd0);
    chk("wide_dropped", 64'(dropped), 64'd5);

    for (int k = 0; k < 30; k++) begin
      rx = 1'b1;
      fw = 1'b1;
      tick();
    end
    rx = 1'b0;
    fw = 1'b0;
    repeat (4) tick();
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    model_clr();
    chk_stats("clr_close", 0, 0, 0, 0);
    chk("clr_close_small", 64'({s_seen, s_dropped, s_passed}), 64'd0);

    cfg_promisc = 1'b1;
    tick();
    chk("promisc_set", 64'(promisc_out), 64'd1);
    cfg_promisc = 1'b0;
    rx = 1'b1;
    tick();
    chk("promisc_defer", 64'(promisc_out), 64'd1);
    expect_close(30, 1'b0);
    frame(29, 1'b0, -1, 6);
    chk("promisc_clear", 64'(promisc_out), 64'd0);

    base = cyc + 1;
    mac_q.push_back('{BROADCAST_MAC, base + 6});
    load_mac(BROADCAST_MAC);
    tick();
    chk("bcast_mac", 64'(mac_out), 64'(BROADCAST_MAC));

    rx = 1'b1;
    repeat (10) tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    base = cyc + 1;
    mac_q.push_back('{DEFAULT_MAC, base});
    rst = 1'b0;
    tick();
    model_clr();
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk_stats("mid_rst", 0, 0, 0, 0);
    chk("mid_rst_mac", 64'(mac_out), 64'(DEFAULT_MAC));
    chk("mid_rst_small_seen", 64'(s_seen), 64'd0);
    rst = 1'b1;
    rx = 1'b0;
    repeat (8) tick();
    chk("post_rst_busy", 64'(busy), 64'd0);

    chk("mac_q_left", 64'(mac_q.size()), 64'd0);
    chk("st_q_left", 64'(st_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
